uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
- Parametrised next-generation UART receiver for the APB-wrapped UART.
- Adds N-times oversampling with a 3-sample majority vote, false-start rejection, optional odd/even parity, 1 or 2 stop bits, and framing/parity/break reporting.
- Sits between the pad-side rx line and the APB register block.
- Consumes a programmable oversample divisor from the baud register.

Parameters:
- DATA_W, 8, data bits per frame; legal range 5..9; sent LSB first.
- OVS, 16, oversample ticks per bit; power of two in 8..16.
- DIV_W, 12, width of the oversample-tick divisor.

Ports:
- clk  in  1  system clock.
- arst_n  in  1  asynchronous active-low reset.
- rst  in  1  synchronous clear; same effect as arst_n.
- rx_en  in  1  receiver enable.
- rx  in  1  asynchronous serial line; idles high.
- baud_div  in  DIV_W  clk cycles per oversample tick, minus 1.
- parity_en  in  1  parity bit present.
- parity_odd  in  1  1 = odd parity, 0 = even.
- two_stop  in  1  two stop bits.
- data  out  DATA_W  last received word.
- valid  out  1  one-cycle pulse: new word on data.
- busy  out  1  frame reception in progress.
- parity_err  out  1  parity status of last word.
- frame_err  out  1  stop-bit status of last word.
- break_det  out  1  break status of last word.

Behaviour:
- Reset (arst_n low or rst high):
  - data=0, valid=0, busy=0, all error flags=0, state=IDLE.
  - Synchroniser flops are set to 1.
- rx passes through a 2-flop synchroniser (rx_s); all sampling uses rx_s.
- Prescaler:
  - Counts 0..baud_div while rx_en=1; tick=1 for one clk at terminal count, then wraps to 0.
  - baud_div=0 gives tick every clk.
  - Held at 0 when rx_en=0.
  - baud_div and cfg inputs are sampled only in IDLE; changes mid-frame have no effect until the next frame.
- Sample counter sc (0..OVS-1):
  - Advances on tick and wraps at OVS-1; cleared on entry to START.
  - Bit value = majority of rx_s at sc=OVS/2-1, OVS/2, OVS/2+1, evaluated on the tick where sc=OVS/2+1.
  - A bit ends on the tick where sc=OVS-1.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HI.
  - IDLE: on tick with rx_s=0 -> START, busy=1.
  - START: if vote=1 (false start) -> IDLE, busy=0, no flags changed. If vote=0 -> DATA at bit end.
  - DATA: shift vote into shift register LSB first; bit index 0..DATA_W-1. After bit DATA_W-1 -> PARITY if parity_en, else STOP1.
  - PARITY: compute expected bit = XOR(data bits) XOR parity_odd. Mismatch sets a pending parity error.
  - STOP1: vote=0 sets a pending frame error. Then go to STOP2 if two_stop, else finish.
  - STOP2: vote=0 sets a pending frame error; then finish.
- Finish (on the vote tick of the last stop bit, not the bit end):
  - data <= shift register; valid=1 on the next clk for exactly one cycle.
  - parity_err and frame_err load their pending values.
  - break_det=1 iff frame error AND all data bits 0 AND (parity_en=0 OR parity bit 0).
  - Flags hold until the next valid.
  - If no frame error -> IDLE, busy=0.
  - If frame error -> WAIT_HI; busy stays 1 until rx_s=1 on a tick, then -> IDLE.
- Latency: valid asserts 1 clk after the majority tick of the final stop bit (plus 2 clk synchroniser delay relative to rx).
- rx_en deasserted in any state:
  - Next clk: state=IDLE, busy=0, prescaler cleared.
  - No valid; data and flags keep their old values.
- rst mid-frame: identical to reset; the frame is discarded.
- Line held low in IDLE after WAIT_HI exit: a new start is accepted only after rx_s is high on at least one tick.

Test Plan:
- Basic 8N1: OVS=16, baud_div=3 (64 clk/bit), send 0xA5, parity_en=0, two_stop=0 -> one valid pulse, data=0xA5, parity_err=frame_err=break_det=0, busy low 1 clk after valid.
- Even parity error: parity_en=1, parity_odd=0, send 0x3C with parity bit 1 -> valid, data=0x3C, parity_err=1. Next frame 0x3C with parity bit 0 -> parity_err=0.
- False start / majority vote:
  - rx low for 4 ticks only -> no valid, busy returns 0, flags unchanged.
  - Frame 0x55 with a 1-tick glitch at sc=OVS/2 on bit 3 -> data=0x55.
- Break: rx low for 12 bit times, then high -> valid, data=0x00, frame_err=1, break_det=1. busy stays 1 until rx high, then a following 0x81 frame is received correctly.
- Two stop bits: two_stop=1, send 0x0F with second stop bit 0 -> frame_err=1, break_det=0, data=0x0F. With both stops 1 -> frame_err=0.
- Abort: drop rx_en during DATA bit 4 of 0xFF -> busy=0 next clk, no valid, data keeps its previous value. Re-enable and send 0x12 -> data=0x12.

Source files
------------

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver. Each bit is sampled OVS times,
// a 3-sample majority vote around mid-bit decides its value. The receiver
// rejects false starts, checks optional parity and 1/2 stop bits, and
// reports parity, framing and break status alongside each received word.
module uart_rx_os #(
  parameter int DATA_W = 8,
  parameter int OVS    = 16,
  parameter int DIV_W  = 12
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              rst,
  input  logic              rx_en,
  input  logic              rx,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              two_stop,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              busy,
  output logic              parity_err,
  output logic              frame_err,
  output logic              break_det
);

  localparam int SC_W  = $clog2(OVS);
  localparam int IDX_W = $clog2(DATA_W);

  localparam logic [SC_W-1:0]  SC_V0    = SC_W'(OVS / 2 - 1);
  localparam logic [SC_W-1:0]  SC_V1    = SC_W'(OVS / 2);
  localparam logic [SC_W-1:0]  SC_V2    = SC_W'(OVS / 2 + 1);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(OVS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_WAIT_HI
  } state_t;

  state_t             r_state, w_next;
  logic               r_rx_meta, r_rx_s;
  logic [DIV_W-1:0]   r_div, r_pre, w_div;
  logic               r_par_en, r_par_odd, r_two_stop;
  logic [SC_W-1:0]    r_sc;
  logic               r_s0, r_s1;
  logic [DATA_W-1:0]  r_shift;
  logic [IDX_W-1:0]   r_idx;
  logic               r_par_bit, r_perr_pend, r_ferr_pend;
  logic [DATA_W-1:0]  r_data;
  logic               r_valid, r_perr, r_ferr, r_brk;
  logic               w_tick, w_vote, w_vote_tick, w_bit_end, w_ferr_now, w_finish;

  // Two-flop synchroniser for the asynchronous line, preset to idle-high.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values, matching real hardware regardless of block order.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Frame configuration tracks the inputs only while idle, so mid-frame
  // changes take effect from the next frame.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_div      <= '0;
      r_par_en   <= 1'b0;
      r_par_odd  <= 1'b0;
      r_two_stop <= 1'b0;
    end else if (rst) begin
      r_div      <= '0;
      r_par_en   <= 1'b0;
      r_par_odd  <= 1'b0;
      r_two_stop <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_div      <= baud_div;
      r_par_en   <= parity_en;
      r_par_odd  <= parity_odd;
      r_two_stop <= two_stop;
    end
  end

  // Idle uses the live divisor; >= keeps the wrap safe if it shrinks.
  assign w_div  = (r_state == S_IDLE) ? baud_div : r_div;
  assign w_tick = rx_en && (r_pre >= w_div);

  // Prescaler: one oversample tick every baud_div+1 clocks while enabled.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)                      r_pre <= '0;
    else if (rst || !rx_en || w_tick) r_pre <= '0;
    else                              r_pre <= r_pre + DIV_W'(1);
  end

  // Sample counter: held at 0 while idle, so it starts at 0 in START.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)                        r_sc <= '0;
    else if (rst || r_state == S_IDLE)  r_sc <= '0;
    else if (w_tick)                    r_sc <= (r_sc == SC_LAST) ? '0 : r_sc + SC_W'(1);
  end

  // Capture the first two of the three mid-bit samples.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_s0 <= 1'b1;
      r_s1 <= 1'b1;
    end else if (rst) begin
      r_s0 <= 1'b1;
      r_s1 <= 1'b1;
    end else if (w_tick) begin
      if (r_sc == SC_V0) r_s0 <= r_rx_s;
      if (r_sc == SC_V1) r_s1 <= r_rx_s;
    end
  end

  assign w_vote      = (r_s0 & r_s1) | (r_s0 & r_rx_s) | (r_s1 & r_rx_s);
  assign w_vote_tick = w_tick && (r_sc == SC_V2);
  assign w_bit_end   = w_tick && (r_sc == SC_LAST);
  assign w_ferr_now  = r_ferr_pend | ~w_vote;

  // FSM state register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)  r_state <= S_IDLE;
    else if (rst) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // FSM next state; the frame finishes on the vote of the last stop bit.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next   = r_state;
    w_finish = 1'b0;
    if (!rx_en) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (w_tick && !r_rx_s) w_next = S_START;
        S_START: begin
          if (w_vote_tick && w_vote) w_next = S_IDLE;
          else if (w_bit_end)        w_next = S_DATA;
        end
        S_DATA:    if (w_bit_end && r_idx == IDX_LAST)
                     w_next = r_par_en ? S_PARITY : S_STOP1;
        S_PARITY:  if (w_bit_end) w_next = S_STOP1;
        S_STOP1: begin
          if (r_two_stop) begin
            if (w_bit_end) w_next = S_STOP2;
          end else if (w_vote_tick) begin
            w_finish = 1'b1;
            w_next   = w_ferr_now ? S_WAIT_HI : S_IDLE;
          end
        end
        S_STOP2: begin
          if (w_vote_tick) begin
            w_finish = 1'b1;
            w_next   = w_ferr_now ? S_WAIT_HI : S_IDLE;
          end
        end
        S_WAIT_HI: if (w_tick && r_rx_s) w_next = S_IDLE;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  // Per-frame datapath: shift register, bit index and pending error status.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_shift     <= '0;
      r_idx       <= '0;
      r_par_bit   <= 1'b0;
      r_perr_pend <= 1'b0;
      r_ferr_pend <= 1'b0;
    end else if (rst || r_state == S_IDLE) begin
      r_shift     <= '0;
      r_idx       <= '0;
      r_par_bit   <= 1'b0;
      r_perr_pend <= 1'b0;
      r_ferr_pend <= 1'b0;
    end else begin
      if (r_state == S_DATA && w_vote_tick) r_shift <= {w_vote, r_shift[DATA_W-1:1]};
      if (r_state == S_DATA && w_bit_end)   r_idx   <= r_idx + IDX_W'(1);
      if (r_state == S_PARITY && w_vote_tick) begin
        r_par_bit   <= w_vote;
        r_perr_pend <= w_vote != (^r_shift ^ r_par_odd);
      end
      if ((r_state == S_STOP1 || r_state == S_STOP2) && w_vote_tick && !w_vote)
        r_ferr_pend <= 1'b1;
    end
  end

  // Output word and status, loaded together with the one-cycle valid pulse.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_brk   <= 1'b0;
    end else if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_brk   <= 1'b0;
    end else begin
      r_valid <= w_finish;
      if (w_finish) begin
        r_data <= r_shift;
        r_perr <= r_perr_pend;
        r_ferr <= w_ferr_now;
        r_brk  <= w_ferr_now && (r_shift == '0) && (!r_par_en || !r_par_bit);
      end
    end
  end

  assign data       = r_data;
  assign valid      = r_valid;
  assign busy       = (r_state != S_IDLE);
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign break_det  = r_brk;

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed frames from a vector table plus hand-written
// sequences for false start, glitch, break, abort and synchronous clear.
module tb_uart_rx_os;

  logic        clk = 1'b0;
  logic        arst_n, rst, rx_en, rx;
  logic [11:0] baud_div;
  logic        parity_en, parity_odd, two_stop;
  logic [7:0]  data;
  logic        valid, busy, parity_err, frame_err, break_det;

  int n_checks = 0;
  int n_errors = 0;

  uart_rx_os #(.DATA_W(8), .OVS(16), .DIV_W(12)) dut (
    .clk(clk), .arst_n(arst_n), .rst(rst), .rx_en(rx_en), .rx(rx),
    .baud_div(baud_div), .parity_en(parity_en), .parity_odd(parity_odd),
    .two_stop(two_stop), .data(data), .valid(valid), .busy(busy),
    .parity_err(parity_err), .frame_err(frame_err), .break_det(break_det)
  );

  always #5 clk = ~clk;

  // Valid-pulse monitor: counts valid cycles and captures word/status.
  int         v_count = 0;
  logic [7:0] cap_data = '0;
  logic       cap_perr = 1'b0, cap_ferr = 1'b0, cap_brk = 1'b0;
  logic       cap_busy_after = 1'b0, prev_valid = 1'b0;
  always @(negedge clk) begin
    prev_valid <= valid;
    if (valid) begin
      v_count  <= v_count + 1;
      cap_data <= data;
      cap_perr <= parity_err;
      cap_ferr <= frame_err;
      cap_brk  <= break_det;
    end
    if (prev_valid) cap_busy_after <= busy;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_line(input logic v, input int clks);
    rx = v;
    repeat (clks) @(negedge clk);
  endtask

  // One frame, LSB first; glitch >= 0 flips a 1/16-bit slice mid-bit there.
  task automatic send_frame(input logic [7:0] d, input bit pen, input bit pbit,
                            input bit ts, input bit s1, input bit s2,
                            input int bt, input int glitch);
    int pre;
    int gw;
    pre = bt * 9 / 16;
    gw  = bt / 16;
    drive_line(1'b0, bt);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch) begin
        drive_line(d[i], pre);
        drive_line(~d[i], gw);
        drive_line(d[i], bt - pre - gw);
      end else begin
        drive_line(d[i], bt);
      end
    end
    if (pen) drive_line(pbit, bt);
    drive_line(s1, bt);
    if (ts) drive_line(s2, bt);
    drive_line(1'b1, bt);
  endtask

  typedef struct {
    logic [7:0]  d;
    logic [11:0] div;
    bit          pen, podd, ts, pbit, s1, s2;
    logic [7:0]  exp_d;
    bit          exp_perr, exp_ferr, exp_brk;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int n0;
    int bt;

    //           d      div    pen podd ts pbit s1 s2  exp_d  perr ferr brk
    vecs[0] = '{8'hA5, 12'd3, 0,  0,   0, 0,   1, 1,  8'hA5, 0,   0,   0};
    vecs[1] = '{8'h3C, 12'd3, 1,  0,   0, 1,   1, 1,  8'h3C, 1,   0,   0};
    vecs[2] = '{8'h3C, 12'd3, 1,  0,   0, 0,   1, 1,  8'h3C, 0,   0,   0};
    vecs[3] = '{8'h0F, 12'd3, 0,  0,   1, 0,   1, 0,  8'h0F, 0,   1,   0};
    vecs[4] = '{8'h0F, 12'd3, 0,  0,   1, 0,   1, 1,  8'h0F, 0,   0,   0};
    vecs[5] = '{8'h01, 12'd3, 1,  1,   0, 0,   1, 1,  8'h01, 0,   0,   0};
    vecs[6] = '{8'h96, 12'd0, 0,  0,   0, 0,   1, 1,  8'h96, 0,   0,   0};
    vecs[7] = '{8'hFF, 12'd3, 0,  0,   0, 0,   1, 1,  8'hFF, 0,   0,   0};
    vecs[8] = '{8'h00, 12'd3, 0,  0,   0, 0,   0, 1,  8'h00, 0,   1,   1};
    vecs[9] = '{8'h00, 12'd3, 1,  0,   0, 1,   0, 1,  8'h00, 1,   1,   0};

    arst_n = 1'b0; rst = 1'b0; rx_en = 1'b0; rx = 1'b1;
    baud_div = 12'd3; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    repeat (3) @(negedge clk);
    arst_n = 1'b1;
    rx_en  = 1'b1;
    repeat (4) @(negedge clk);
    check("reset data", data, 8'h00);
    check("reset valid", valid, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset parity_err", parity_err, 1'b0);
    check("reset frame_err", frame_err, 1'b0);
    check("reset break_det", break_det, 1'b0);

    // Table-driven frames.
    for (int k = 0; k < 10; k++) begin
      baud_div   = vecs[k].div;
      parity_en  = vecs[k].pen;
      parity_odd = vecs[k].podd;
      two_stop   = vecs[k].ts;
      bt = (int'(vecs[k].div) + 1) * 16;
      drive_line(1'b1, 2 * bt);
      n0 = v_count;
      send_frame(vecs[k].d, vecs[k].pen, vecs[k].pbit, vecs[k].ts,
                 vecs[k].s1, vecs[k].s2, bt, -1);
      check($sformatf("vec%0d valid pulses", k), v_count - n0, 1);
      check($sformatf("vec%0d data", k), cap_data, vecs[k].exp_d);
      check($sformatf("vec%0d parity_err", k), cap_perr, vecs[k].exp_perr);
      check($sformatf("vec%0d frame_err", k), cap_ferr, vecs[k].exp_ferr);
      check($sformatf("vec%0d break_det", k), cap_brk, vecs[k].exp_brk);
      check($sformatf("vec%0d busy after valid", k), cap_busy_after, vecs[k].exp_ferr);
    end

    // False start: 4 ticks low, then high. Flags from vec9 must survive.
    drive_line(1'b1, 128);
    n0 = v_count;
    drive_line(1'b0, 12);
    check("false start busy high", busy, 1'b1);
    drive_line(1'b0, 4);
    drive_line(1'b1, 80);
    check("false start busy low", busy, 1'b0);
    check("false start no valid", v_count - n0, 0);
    check("false start parity_err kept", parity_err, 1'b1);
    check("false start frame_err kept", frame_err, 1'b1);

    // Majority vote filters a one-tick glitch on bit 3.
    parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0; baud_div = 12'd3;
    drive_line(1'b1, 128);
    n0 = v_count;
    send_frame(8'h55, 0, 0, 0, 1, 1, 64, 3);
    check("glitch valid pulses", v_count - n0, 1);
    check("glitch data", cap_data, 8'h55);
    check("glitch frame_err", cap_ferr, 1'b0);

    // Break: 12 bit times low, then recovery and a normal frame.
    drive_line(1'b1, 128);
    n0 = v_count;
    drive_line(1'b0, 12 * 64);
    check("break valid pulses", v_count - n0, 1);
    check("break data", cap_data, 8'h00);
    check("break frame_err", cap_ferr, 1'b1);
    check("break break_det", cap_brk, 1'b1);
    check("break parity_err", cap_perr, 1'b0);
    check("break busy while low", busy, 1'b1);
    drive_line(1'b1, 64);
    check("break busy after high", busy, 1'b0);
    drive_line(1'b1, 64);
    n0 = v_count;
    send_frame(8'h81, 0, 0, 0, 1, 1, 64, -1);
    check("post-break valid pulses", v_count - n0, 1);
    check("post-break data", cap_data, 8'h81);
    check("post-break frame_err", cap_ferr, 1'b0);
    check("post-break break_det", cap_brk, 1'b0);

    // Abort: drop rx_en in the middle of data bit 4 of 0xFF.
    drive_line(1'b1, 128);
    n0 = v_count;
    drive_line(1'b0, 64);
    drive_line(1'b1, 4 * 64 + 32);
    check("abort busy before drop", busy, 1'b1);
    rx_en = 1'b0;
    @(negedge clk);
    check("abort busy next clk", busy, 1'b0);
    drive_line(1'b1, 10 * 64);
    check("abort no valid", v_count - n0, 0);
    check("abort data kept", data, 8'h81);
    rx_en = 1'b1;
    drive_line(1'b1, 128);
    n0 = v_count;
    send_frame(8'h12, 0, 0, 0, 1, 1, 64, -1);
    check("re-enable valid pulses", v_count - n0, 1);
    check("re-enable data", cap_data, 8'h12);

    // Synchronous clear mid-frame discards the frame and clears outputs.
    drive_line(1'b1, 128);
    n0 = v_count;
    drive_line(1'b0, 64 + 2 * 64);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst busy", busy, 1'b0);
    check("rst data", data, 8'h00);
    drive_line(1'b1, 12 * 64);
    check("rst no valid", v_count - n0, 0);
    check("rst busy idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
